// File: rtl/cmos_capture_pkg.sv
// rtl/cmos_capture_pkg.sv - shared pixel format, colour-bar constants and capture state type
package cmos_capture_pkg;

  // RGB565 field widths, shared with the display side
  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  // Default frame geometry, matching the vga_driver side
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  // Colour bars in RGB565, left to right
  localparam logic [PIX_W-1:0] CB_WHITE   = 16'hFFFF;
  localparam logic [PIX_W-1:0] CB_YELLOW  = 16'hFFE0;
  localparam logic [PIX_W-1:0] CB_CYAN    = 16'h07FF;
  localparam logic [PIX_W-1:0] CB_GREEN   = 16'h07E0;
  localparam logic [PIX_W-1:0] CB_MAGENTA = 16'hF81F;
  localparam logic [PIX_W-1:0] CB_RED     = 16'hF800;
  localparam logic [PIX_W-1:0] CB_BLUE    = 16'h001F;
  localparam logic [PIX_W-1:0] CB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {SKIP, WAIT, CAPT} cap_state_t;

  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    return CB_WHITE;
      3'd1:    return CB_YELLOW;
      3'd2:    return CB_CYAN;
      3'd3:    return CB_GREEN;
      3'd4:    return CB_MAGENTA;
      3'd5:    return CB_RED;
      3'd6:    return CB_BLUE;
      default: return CB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cmos_capture_if.sv
// rtl/cmos_capture_if.sv - RGB565 pixel stream toward the SDRAM input FIFO
interface cmos_capture_if;
  import cmos_capture_pkg::*;

  logic [PIX_W-1:0] dout;
  logic             dout_vld;
  logic             dout_sop;
  logic             dout_eop;
  logic             dout_rdy;

  modport master (output dout, output dout_vld, output dout_sop, output dout_eop, input dout_rdy);
  modport slave  (input dout, input dout_vld, input dout_sop, input dout_eop, output dout_rdy);

endinterface

// File: rtl/cmos_byte_pack.sv
// rtl/cmos_byte_pack.sv - pairs sensor bytes into 16-bit pixels, high byte first
module cmos_byte_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        hr,
  input  logic [7:0]  d,
  output logic        phase,
  output logic        stb,
  output logic [15:0] pix
);

  logic [7:0] hi;

  // Toggle byte phase on every active byte; hold the high byte on phase 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      hi    <= 8'h00;
    end else if (clr) begin
      phase <= 1'b0;
    end else if (en && hr) begin
      phase <= ~phase;
      if (!phase) hi <= d;
    end
  end

  // Pixel is complete while the low byte is present
  assign stb = en & hr & phase;
  assign pix = {hi, d};

endmodule

// File: rtl/cmos_capture.sv
// rtl/cmos_capture.sv - DVP capture to RGB565 stream with settling-frame skip; CMOS_CAPTURE_TEST_PATTERN_EN selects colour bars
module cmos_capture
  import cmos_capture_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int SKIP_FRAMES = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmos_vsync,
  input  logic                  cmos_href,
  input  logic [7:0]            cmos_data,
  input  logic                  capture_en,
  input  logic                  err_clr,
  cmos_capture_if.master        dout_if,
  output logic                  line_err,
  output logic                  frame_err,
  output logic                  ovf
);

  localparam int XW  = $clog2(IMG_W + 1);
  localparam int YW  = $clog2(IMG_H + 1);
  localparam int SKW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  localparam logic [XW-1:0]  X_END     = XW'(IMG_W);
  localparam logic [XW-1:0]  X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_END     = YW'(IMG_H);
  localparam logic [YW-1:0]  Y_LAST    = YW'(IMG_H - 1);
  localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
  localparam cap_state_t     ST_RST    = (SKIP_FRAMES == 0) ? WAIT : SKIP;

  logic             vs_r, vs_d, hr_r, hr_d;
  logic [7:0]       d_r;
  cap_state_t       state;
  logic [SKW-1:0]   skip_cnt;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             vs_rise, hr_fall;
  logic             pk_phase, pk_stb;
  logic [15:0]      pk_pix;
  logic             pix_ok, at_sop, at_eop;
  logic [PIX_W-1:0] pix_out;

  // Register the sensor pins once, plus a second stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r <= 1'b0;
      vs_d <= 1'b0;
      hr_r <= 1'b0;
      hr_d <= 1'b0;
      d_r  <= 8'h00;
    end else begin
      vs_r <= cmos_vsync;
      vs_d <= vs_r;
      hr_r <= cmos_href;
      hr_d <= hr_r;
      d_r  <= cmos_data;
    end
  end

  assign vs_rise = vs_r & ~vs_d;
  assign hr_fall = ~hr_r & hr_d;

  cmos_byte_pack u_pack (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == CAPT),
    .clr   (vs_rise | hr_fall),
    .hr    (hr_r),
    .d     (d_r),
    .phase (pk_phase),
    .stb   (pk_stb),
    .pix   (pk_pix)
  );

  assign pix_ok = pk_stb && (x < X_END) && (y < Y_END);
  assign at_sop = (x == '0) && (y == '0);
  assign at_eop = (x == X_LAST) && (y == Y_LAST);

`ifdef CMOS_CAPTURE_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar     = 3'((int'(x) * 8) / IMG_W);
  assign pix_out = bar_color(bar);
`else
  assign pix_out = pk_pix;
`endif

  // Frame FSM, position counters, registered stream outputs and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_RST;
      skip_cnt         <= '0;
      x                <= '0;
      y                <= '0;
      dout_if.dout     <= '0;
      dout_if.dout_vld <= 1'b0;
      dout_if.dout_sop <= 1'b0;
      dout_if.dout_eop <= 1'b0;
      line_err         <= 1'b0;
      frame_err        <= 1'b0;
      ovf              <= 1'b0;
    end else begin
      dout_if.dout_vld <= 1'b0;
      dout_if.dout_sop <= 1'b0;
      dout_if.dout_eop <= 1'b0;
      // Clear first so a same-cycle set below takes priority
      if (err_clr) begin
        line_err  <= 1'b0;
        frame_err <= 1'b0;
        ovf       <= 1'b0;
      end
      case (state)
        SKIP: begin
          if (vs_rise) begin
            if (skip_cnt == SKIP_LAST) state <= WAIT;
            else                       skip_cnt <= skip_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (vs_rise && capture_en) begin
            state <= CAPT;
            x     <= '0;
            y     <= '0;
          end
        end
        CAPT: begin
          if (vs_rise) begin
            // Frame cut short: restart immediately if still enabled
            frame_err <= 1'b1;
            x         <= '0;
            y         <= '0;
            if (!capture_en) state <= WAIT;
          end else begin
            if (pix_ok) begin
              x <= x + 1'b1;
              if (dout_if.dout_rdy) begin
                dout_if.dout     <= pix_out;
                dout_if.dout_vld <= 1'b1;
                dout_if.dout_sop <= at_sop;
                dout_if.dout_eop <= at_eop;
              end else begin
                ovf <= 1'b1;
              end
              if (at_eop) state <= WAIT;
            end
            if (hr_fall) begin
              if ((y < Y_END) && (pk_phase || (x < X_END))) line_err <= 1'b1;
              x <= '0;
              if (y < Y_END) y <= y + 1'b1;
            end
          end
        end
        default: state <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_capture.sv
// tb/tb_cmos_capture.sv - self-checking bench for cmos_capture with a frame-level reference model
module tb_cmos_capture;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int SK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0;
  logic       hr = 1'b0;
  logic [7:0] d = 8'h00;
  logic       cen = 1'b1;
  logic       clr = 1'b0;
  logic       le, fe, ov;

  cmos_capture_if bus ();

  cmos_capture #(.IMG_W(W), .IMG_H(H), .SKIP_FRAMES(SK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmos_vsync (vs),
    .cmos_href  (hr),
    .cmos_data  (d),
    .capture_en (cen),
    .err_clr    (clr),
    .dout_if    (bus),
    .line_err   (le),
    .frame_err  (fe),
    .ovf        (ov)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [17:0] got_q[$];
  int          got_cyc[$];
  logic [17:0] exp_q[$];
  logic [7:0]  lb[$];

  int m_skip;
  bit m_active;
  int m_y;
  bit e_le, e_fe, e_ov;
  int line_t1, f_lat;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every delivered pixel as {sop, eop, data}
  always @(negedge clk) begin
    if (rst_n && bus.dout_vld) begin
      got_q.push_back({bus.dout_sop, bus.dout_eop, bus.dout});
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic [7:0] dd, input logic r);
    @(posedge clk);
    #1;
    vs = v;
    hr = h;
    d = dd;
    bus.dout_rdy = r;
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (4) step(1'b0, 1'b0, 8'h00, 1'b1);
    if (m_skip > 0) begin
      m_skip--;
      m_active = 0;
    end else begin
      if (m_active) e_fe = 1;
      m_active = cen;
      m_y = 0;
    end
  endtask

  // Send the bytes in lb as one line; drop_k selects a pixel to present with dout_rdy low
  task automatic send_line(input int drop_k);
    int n, np;
    bit eop_hit;
    logic [7:0] b;
    n = lb.size();
    for (int i = 0; i < n + 4; i++) begin
      b = 8'h00;
      if (i < n) b = lb[i];
      step(1'b0, i < n, b, !(drop_k >= 0 && i == 2 * drop_k + 2));
      if (i == 1) line_t1 = cyc + 1;
    end
    eop_hit = 0;
    if (m_active && m_y < H) begin
      np = n / 2;
      if (np > W) np = W;
      for (int k = 0; k < np; k++) begin
        if (k == drop_k) e_ov = 1;
        else exp_q.push_back({(m_y == 0 && k == 0), (m_y == H - 1 && k == W - 1), lb[2*k], lb[2*k+1]});
        if (m_y == H - 1 && k == W - 1) eop_hit = 1;
      end
      if (!eop_hit && ((n % 2) != 0 || (n / 2) < W)) e_le = 1;
      if (eop_hit) m_active = 0;
      m_y++;
    end
  endtask

  task automatic frame(input int nlines, input int n0, input bit ramp, input int drop_k);
    vsync_pulse();
    for (int yy = 0; yy < nlines; yy++) begin
      int n;
      n = (yy == 0) ? n0 : 2 * W;
      lb.delete();
      for (int i = 0; i < n; i++) lb.push_back(ramp ? 8'(yy * 2 * W + i) : 8'($urandom_range(0, 255)));
      send_line(yy == 0 ? drop_k : -1);
      if (yy == 0) f_lat = line_t1;
    end
  endtask

  task automatic check_frame(input string nm, input bit do_lat);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, ":count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s:pix%0d", nm, i), got_q[i], exp_q[i]);
    if (do_lat && got_cyc.size() > 0) chk({nm, ":latency"}, got_cyc[0], f_lat + 1);
    chk({nm, ":line_err"}, le, e_le);
    chk({nm, ":frame_err"}, fe, e_fe);
    chk({nm, ":ovf"}, ov, e_ov);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic clear_err(input string nm);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(posedge clk); #1;
    e_le = 0; e_fe = 0; e_ov = 0;
    chk({nm, ":clr_le"}, le, e_le);
    chk({nm, ":clr_fe"}, fe, e_fe);
    chk({nm, ":clr_ovf"}, ov, e_ov);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, ":vld"}, bus.dout_vld, 0);
    chk({nm, ":dout"}, bus.dout, 0);
    chk({nm, ":sop"}, bus.dout_sop, 0);
    chk({nm, ":eop"}, bus.dout_eop, 0);
    chk({nm, ":le"}, le, 0);
    chk({nm, ":fe"}, fe, 0);
    chk({nm, ":ovf"}, ov, 0);
  endtask

  initial begin
    bus.dout_rdy = 1'b1;
    m_skip = SK; m_active = 0; m_y = 0;
    e_le = 0; e_fe = 0; e_ov = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Settling frames produce nothing; third ramp frame is captured
    frame(2, 8, 1'b1, -1);
    frame(2, 8, 1'b1, -1);
    check_frame("skip", 1'b0);
    frame(2, 8, 1'b1, -1);
    check_frame("ramp", 1'b1);

    // Odd byte count on a line
    frame(2, 7, 1'b0, -1);
    check_frame("odd", 1'b0);
    clear_err("odd");

    // Frame cut short by vsync, next one captured
    frame(1, 8, 1'b0, -1);
    frame(2, 8, 1'b0, -1);
    check_frame("short", 1'b0);
    clear_err("short");

    // One pixel refused by downstream
    frame(2, 8, 1'b0, 1);
    check_frame("drop", 1'b0);
    clear_err("drop");

    // Capture disabled for one frame, then enabled
    cen = 1'b0;
    frame(2, 8, 1'b0, -1);
    cen = 1'b1;
    check_frame("cen_off", 1'b0);
    frame(2, 8, 1'b0, -1);
    check_frame("cen_on", 1'b0);

    // Reset in the middle of a line after a short line set line_err
    vsync_pulse();
    lb.delete();
    for (int i = 0; i < 5; i++) lb.push_back(8'($urandom_range(0, 255)));
    send_line(-1);
    chk("pre_rst:le", le, e_le);
    repeat (3) step(1'b0, 1'b1, 8'($urandom_range(1, 255)), 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    rst_n = 1'b1;
    m_skip = SK; m_active = 0; m_y = 0;
    e_le = 0; e_fe = 0; e_ov = 0;
    got_q.delete(); got_cyc.delete(); exp_q.delete();

    frame(2, 8, 1'b0, -1);
    frame(2, 8, 1'b0, -1);
    check_frame("rskip", 1'b0);
    frame(2, 8, 1'b0, -1);
    check_frame("rcap", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmos_capture.md
# cmos_capture

Pixel-stream source at the camera end of the frame path. Receives the 8-bit DVP interface of the CMOS sensor (vsync/href/data, clocked by the sensor pixel clock), and discards a configurable number of settling frames after reset. Assembles byte pairs into RGB565 pixels and emits a dout/dout_vld/dout_sop/dout_eop stream into the input FIFO feeding SDRAM, the same stream format the display side consumes. Flags malformed lines/frames and FIFO overflow.

## Interface
- IMG_W, 640, active pixels per line captured
- IMG_H, 480, active lines per frame captured
- SKIP_FRAMES, 10, vsync rising edges ignored after reset before capture starts (0 = capture first frame)

- clk  in  1  sensor pixel clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmos_vsync  in  1  frame sync, active-high pulse at frame start
- cmos_href  in  1  line valid, high during active bytes
- cmos_data  in  8  sensor byte, high byte of pixel first
- capture_en  in  1  frame capture enable, sampled at vsync rising edge
- dout_rdy  in  1  downstream FIFO can accept a pixel
- err_clr  in  1  one-cycle clear of sticky status bits
- dout  out  16  RGB565 pixel
- dout_vld  out  1  pixel valid, one cycle per pixel
- dout_sop  out  1  with dout_vld, first pixel of frame (x=0,y=0)
- dout_eop  out  1  with dout_vld, last pixel of frame (x=IMG_W-1,y=IMG_H-1)
- line_err  out  1  sticky: odd byte count at href fall, or line shorter than IMG_W
- frame_err  out  1  sticky: vsync rose before IMG_H complete lines of a captured frame
- ovf  out  1  sticky: pixel produced while dout_rdy low (pixel dropped)

## Operation
- Inputs registered once (vs_r, hr_r, d_r); edges detected on registered copies against a second delay stage.
- All outputs reset to 0; counters, byte phase, frame counter reset to 0; state reset to SKIP (or WAIT when SKIP_FRAMES=0).
- States: SKIP -> WAIT -> CAPT -> WAIT.
  - SKIP: count vsync rising edges; on edge number SKIP_FRAMES go to WAIT. No output.
  - WAIT: on vsync rising edge, if capture_en=1 go to CAPT and clear x, y, byte phase; else stay.
  - CAPT: on each hr_r=1 cycle toggle byte phase; phase 0 stores d_r as [15:8], phase 1 forms pixel {hi,d_r}. Pixel emitted if x<IMG_W and y<IMG_H; x increments per formed pixel, saturating at IMG_W.
  - href falling edge: if phase=1 or x<IMG_W (while y<IMG_H) set line_err; clear phase and x; increment y (saturating at IMG_H).
  - After eop emitted, go to WAIT. Vsync rising edge in CAPT before eop: set frame_err, treat as WAIT edge (restart if capture_en=1).
- Emitted pixel with dout_rdy=0: dout_vld stays 0, ovf set; x still advances (position kept). If the dropped pixel carried sop/eop, the marker is lost; eop still moves state to WAIT.
- err_clr clears all sticky bits; a set event in the same cycle wins.
- Bytes beyond IMG_W per line and lines beyond IMG_H are ignored, not errors.

## Timing
- Low byte on pins before edge t is registered at t; dout/dout_vld/sop/eop valid after edge t+1 (2-cycle pin-to-output latency).
- dout_vld at most every second cycle; no combinational path from inputs to outputs.
- dout_rdy sampled in the same cycle the pixel is formed (edge t+1).
- Sticky bits set on edge following the detecting condition.
- Reset mid-frame: everything returns to SKIP; SKIP_FRAMES settling repeats.

## Configuration
- CMOS_CAPTURE_TEST_PATTERN_EN defined: dout replaced by 8 vertical colour bars (bar = x*8/IMG_W: white, yellow, cyan, green, magenta, red, blue, black in RGB565); all timing, sop/eop, and error logic unchanged and still driven by sensor sync.
- Undefined: dout carries sensor data; pattern logic absent.

## Structure
- Shared package: RGB565 field widths, colour-bar constants, state enum (SKIP, WAIT, CAPT), default IMG_W/IMG_H shared with vga_driver side.
- One sub-module: cmos_byte_pack (byte phase, high-byte hold, pixel-formed strobe); FSM, counters, and flags in top.

## Test plan
- SKIP_FRAMES=2, 3 frames of 4x2 (IMG_W=4, IMG_H=2) ramp bytes -> no output for frames 1-2; frame 3 yields 8 pixels, sop on first (0x0001), eop on 8th, 2-cycle latency.
- href with 7 bytes -> line_err=1; remaining frame pixels still counted from next line x=0.
- vsync rises after 1 of 2 lines -> frame_err=1; next frame captured with sop.
- dout_rdy=0 for one formed pixel -> that pixel absent, ovf=1; err_clr -> ovf=0.
- capture_en=0 at a vsync edge -> whole frame ignored; set to 1 -> next frame captured.
- rst_n asserted mid-line -> all outputs 0 immediately, skip count restarts.
